// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder family.
package decoder_pkg;

  localparam int DEC_IN_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } dec_state_t;

  // Bits needed to count 0..value-1, never less than one so a DWELL of 1 still has a register.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an enable that forces all zeros.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W
) (
  input  logic                  i_en,
  input  logic [IN_W-1:0]       i_idx,
  output logic [(2**IN_W)-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with direct-index and auto-scan modes.
// Scan mode walks every output line with a programmable dwell and pulses wrap per sweep.
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int IN_W    = DEC_IN_W,
  parameter int DWELL   = 4,
  parameter int ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  E,
  input  logic                  mode,
  input  logic                  hold,
  input  logic [IN_W-1:0]       In,
  output logic [(2**IN_W)-1:0]  Out,
  output logic [IN_W-1:0]       idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**IN_W;
  localparam int DW    = clog2_min1(DWELL);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [OUT_W-1:0] INACTIVE   = (ACT_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  dec_state_t       r_state, w_state_n;
  logic [IN_W-1:0]  r_idx, w_idx_n;
  logic [DW-1:0]    r_dwell, w_dwell_n;
  logic             r_wrap, w_wrap_n;
  logic [OUT_W-1:0] r_out, w_out_n;
  logic             w_sel_en;
  logic [OUT_W-1:0] w_onehot;

  // Next-index mux: Out is always decoded from w_idx_n, so it can never go multi-hot on a mode switch.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_dwell_n = r_dwell;
    w_wrap_n  = 1'b0;
    w_sel_en  = 1'b1;
    if (!E) begin
      w_state_n = IDLE;
      w_sel_en  = 1'b0;
      w_dwell_n = '0;
    end else if (!mode) begin
      w_state_n = DIRECT;
      w_idx_n   = In;
      w_dwell_n = '0;
    end else if (r_state != SCAN) begin
      w_state_n = SCAN;
      w_idx_n   = '0;
      w_dwell_n = '0;
    end else if (hold) begin
      w_state_n = SCAN;
    end else if (r_dwell != DWELL_LAST) begin
      w_dwell_n = r_dwell + 1'b1;
    end else begin
      w_dwell_n = '0;
      w_idx_n   = r_idx + 1'b1;
      w_wrap_n  = &r_idx;
    end
  end

  onehot_dec #(
    .IN_W (IN_W)
  ) u_onehot_dec (
    .i_en     (w_sel_en),
    .i_idx    (w_idx_n),
    .o_onehot (w_onehot)
  );

  // Polarity is folded in before the register so reset loads the true inactive level.
  assign w_out_n = w_onehot ^ INACTIVE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dwell <= '0;
      r_wrap  <= 1'b0;
      r_out   <= INACTIVE;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_dwell <= w_dwell_n;
      r_wrap  <= w_wrap_n;
      r_out   <= w_out_n;
    end
  end

  assign Out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
